// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg
// Shared definitions for the DMem access controller: request size encoding,
// controller state enum and the default DMem depth.
// Optional build macro used by the controller: DMEM_MISALIGN_TRAP_EN.
package dmem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam int DMEM_DEPTH_WORDS = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
// Combinational little-endian lane logic for sub-word accesses.
//   word       : 32-bit word read from DMem
//   offset     : byte offset within the word (already alignment-adjusted)
//   size       : access size (byte/half/word)
//   uns        : 1 = zero-extend loads, 0 = sign-extend
//   store_data : right-aligned store data (only the low half is ever merged)
//   load_data  : extracted and extended load value
//   merge_data : word with the target lane replaced by store data
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    bsh        = {offset, 3'b000};
    hsh        = {offset[1], 4'b0000};
    byte_sel   = word[bsh +: 8];
    half_sel   = word[hsh +: 16];
    load_data  = word;
    merge_data = word;
    case (size)
      SIZE_BYTE: begin
        load_data  = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merge_data = (word & ~(32'h0000_00FF << bsh)) |
                     ({24'h0, store_data[7:0]} << bsh);
      end
      SIZE_HALF: begin
        load_data  = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_data = (word & ~(32'h0000_FFFF << hsh)) |
                     ({16'h0, store_data} << hsh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Memory-stage controller in front of a word-wide DMem. Accepts load/store
// requests on a valid/ready handshake, converts byte addresses to word
// indices, extends sub-word loads and performs sub-word stores as
// read-modify-write. All DMem control outputs are registered.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   req_valid/req_ready            : request handshake
//   req_we, req_size, req_unsigned : request type, size, load extension
//   req_addr, req_wdata            : byte address, right-aligned store data
//   resp_valid/resp_ready          : response handshake
//   resp_rdata, resp_err           : load data (0 for stores/errors), error
//   Ewr, Erd, Addr, RDir, MOut     : DMem write/read enable, word index,
//                                    write data, read data
// Build macro: DMEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
// accesses are errors; otherwise the low address bits are ignored.
//
// state  | meaning
// IDLE   | ready for a request
// RD     | Erd high, capture and extend the load lane
// WR     | Ewr high, full-word store
// RMW_RD | Erd high, read word and build the merged store word
// RMW_WR | Ewr high, write the merged word
// RESP   | resp_valid held until resp_ready
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        Ewr,
  output logic        Erd,
  output logic [31:0] Addr,
  output logic [31:0] RDir,
  input  logic [31:0] MOut
);

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic        out_of_range;
  logic        misalign;
  logic        req_err;
  logic [1:0]  off_eff;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_TRAP_EN
    case (req_size)
      SIZE_HALF: misalign = req_addr[0];
      SIZE_WORD: misalign = (req_addr[1:0] != 2'b00);
      default:   misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
    req_err = (req_size == SIZE_ILL) || out_of_range || misalign;
    // Below-alignment bits are dropped so lane selection stays natural.
    case (req_size)
      SIZE_BYTE: off_eff = req_addr[1:0];
      SIZE_HALF: off_eff = {req_addr[1], 1'b0};
      default:   off_eff = 2'b00;
    endcase
  end

  dmem_lane_align u_lane_align (
    .word       (MOut),
    .offset     (off_q),
    .size       (size_q),
    .uns        (uns_q),
    .store_data (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      size_q     <= SIZE_BYTE;
      off_q      <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      Ewr        <= 1'b0;
      Erd        <= 1'b0;
      Addr       <= '0;
      RDir       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            size_q     <= req_size;
            off_q      <= off_eff;
            uns_q      <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= ST_RESP;
            end else begin
              Addr <= {2'b00, req_addr[31:2]};
              if (!req_we) begin
                Erd   <= 1'b1;
                state <= ST_RD;
              end else if (req_size == SIZE_WORD) begin
                Ewr   <= 1'b1;
                RDir  <= req_wdata;
                state <= ST_WR;
              end else begin
                Erd   <= 1'b1;
                state <= ST_RMW_RD;
              end
            end
          end
        end
        ST_RD: begin
          Erd        <= 1'b0;
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_WR: begin
          Ewr        <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RMW_RD: begin
          // RDir doubles as the merge buffer so it is stable through RMW_WR.
          Erd   <= 1'b0;
          Ewr   <= 1'b1;
          RDir  <= merge_data;
          state <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          Ewr        <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          Ewr       <= 1'b0;
          Erd       <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl
// Directed bench for dmem_access_ctrl with a small behavioural DMem model
// (combinational read, write on the clock edge while Ewr is high).
// Honours DMEM_MISALIGN_TRAP_EN for the misaligned-access vectors.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        Ewr;
  logic        Erd;
  logic [31:0] Addr;
  logic [31:0] RDir;
  logic [31:0] MOut;

  logic [31:0] mem [0:31];
  logic        saw_erd;
  logic        both_hi;
  logic [31:0] last_wr;

  int n_chk;
  int n_pass;

  dmem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .Ewr          (Ewr),
    .Erd          (Erd),
    .Addr         (Addr),
    .RDir         (RDir),
    .MOut         (MOut)
  );

  always #5 clk = ~clk;

  assign MOut = mem[Addr[4:0]];

  always @(posedge clk) begin
    if (Ewr) mem[Addr[4:0]] <= RDir;
  end

  always @(negedge clk) begin
    if (Ewr && Erd) both_hi = 1'b1;
    if (Erd) saw_erd = 1'b1;
    if (Ewr) last_wr = RDir;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // One request; returns response data, error flag and latency in edges
  // counted from the accept edge. hold = cycles with resp_ready low.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    saw_erd      = 1'b0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    n_chk = 0; n_pass = 0;
    clk = 1'b0; rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    saw_erd = 1'b0; both_hi = 1'b0; last_wr = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[31] = 32'h3131_3131;

    #12;
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
    chk("rst_ewr",        {31'b0, Ewr},        32'd0);
    chk("rst_erd",        {31'b0, Erd},        32'd0);
    chk("rst_addr",       Addr,                32'd0);
    chk("rst_rdir",       RDir,                32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SW then LW at 0x10
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
    chk("sw_lat",    lat,       32'd2);
    chk("sw_err",    {31'b0, er}, 32'd0);
    chk("sw_rdata",  rd,        32'd0);
    chk("sw_rdir",   last_wr,   32'hDEAD_BEEF);
    chk("sw_mem",    mem[4],    32'hDEAD_BEEF);
    chk("ready_back",{31'b0, req_ready}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("lw_rdata",  rd,        32'hDEAD_BEEF);
    chk("lw_lat",    lat,       32'd2);
    chk("lw_addr",   Addr,      32'd4);
    chk("lw_err",    {31'b0, er}, 32'd0);

    // Clear word 4, SB 0x80 at 0x11
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF80, 0, rd, er, lat);
    chk("sb_lat",    lat,       32'd3);
    chk("sb_rdir",   last_wr,   32'h0000_8000);
    chk("sb_mem",    mem[4],    32'h0000_8000);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, rd, er, lat);
    chk("lb_s",      rd,        32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, rd, er, lat);
    chk("lbu",       rd,        32'h0000_0080);

    // SH 0xABCD at 0x12
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD, 0, rd, er, lat);
    chk("sh_mem",    mem[4],    32'hABCD_8000);
    chk("sh_rdir",   last_wr,   32'hABCD_8000);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, rd, er, lat);
    chk("lh_s",      rd,        32'hFFFF_ABCD);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, rd, er, lat);
    chk("lhu",       rd,        32'h0000_ABCD);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd, er, lat);
    chk("lb_off3",   rd,        32'hFFFF_FFAB);

    // Misaligned accesses
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_mis_err",   {31'b0, er},      32'd1);
    chk("lw_mis_lat",   lat,              32'd1);
    chk("lw_mis_noerd", {31'b0, saw_erd}, 32'd0);
    chk("lw_mis_rdata", rd,               32'd0);
`else
    chk("lw_mis_err",   {31'b0, er},      32'd0);
    chk("lw_mis_rdata", rd,               32'hABCD_8000);
    chk("lw_mis_lat",   lat,              32'd2);
`endif
    do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_1234, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("sh_mis_err",   {31'b0, er}, 32'd1);
    chk("sh_mis_mem",   mem[4],      32'hABCD_8000);
`else
    chk("sh_mis_err",   {31'b0, er}, 32'd0);
    chk("sh_mis_mem",   mem[4],      32'hABCD_1234);
`endif

    // Range boundary and illegal size
    do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 0, rd, er, lat);
    chk("oor_err",    {31'b0, er},      32'd1);
    chk("oor_lat",    lat,              32'd1);
    chk("oor_noerd",  {31'b0, saw_erd}, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 0, rd, er, lat);
    chk("last_err",   {31'b0, er},      32'd0);
    chk("last_rdata", rd,               32'h3131_3131);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("ill_err",    {31'b0, er},      32'd1);
    chk("ill_rdata",  rd,               32'd0);

    // Backpressure: hold resp_ready low for 5 cycles
    do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 5, rd, er, lat);
    chk("hold_data",  rd,               32'h3131_3131);
    chk("hold_after", {31'b0, req_ready}, 32'd1);

    // Reset while in RMW_WR
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_rd_erd", {31'b0, Erd}, 32'd1);
    @(posedge clk); #1;
    chk("rmw_wr_ewr", {31'b0, Ewr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ewr",   {31'b0, Ewr},        32'd0);
    chk("mid_rst_erd",   {31'b0, Erd},        32'd0);
    chk("mid_rst_addr",  Addr,                32'd0);
    chk("mid_rst_rdir",  RDir,                32'd0);
    chk("mid_rst_ready", {31'b0, req_ready},  32'd1);
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 0, rd, er, lat);
    chk("post_rst_rdata", rd, 32'h3131_3131);

    chk("never_both_en", {31'b0, both_hi}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage access controller sitting directly upstream of the word-wide data memory (DMem). It accepts load/store requests from the execute stage over a valid/ready handshake, converts byte addresses to word indices, performs sign/zero extension for sub-word loads, and implements sub-word stores as read-modify-write. It drives DMem's `Ewr`, `Erd`, `Addr` and `RDir` from registers and samples `MOut`.

## Interface
- `DEPTH_WORDS`, 32: number of 32-bit words in DMem; word indices at or above this value are out of range.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal (flagged as error).
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response held until `resp_ready`.
- `resp_ready` in 1: consumer accepts response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, out-of-range or illegal-size request.
- `Ewr` out 1: DMem write enable.
- `Erd` out 1: DMem read enable.
- `Addr` out 32: DMem word index, `req_addr >> 2`.
- `RDir` out 32: DMem write data.
- `MOut` in 32: DMem read data (combinational).

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request.
  - Error request -> RESP with `resp_err`=1, no DMem access.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RMW_RD.
- RD: `Erd`=1; capture `MOut`, extract lane, extend into `resp_rdata` -> RESP.
- WR: `Ewr`=1, `RDir`=`req_wdata` -> RESP.
- RMW_RD: `Erd`=1; capture `MOut` into merge buffer -> RMW_WR.
- RMW_WR: `Ewr`=1; `RDir`= buffer with the target lane replaced by low bits of `req_wdata` -> RESP.
- RESP: `resp_valid`=1; on `resp_ready` -> IDLE.
- Lane mapping is little-endian:
  - Byte: offset `addr[1:0]` selects bits `[8*off+7 : 8*off]`.
  - Half: `addr[1]`=0 selects `[15:0]`, `addr[1]`=1 selects `[31:16]`.
- Out of range: `req_addr[31:2]` >= `DEPTH_WORDS` -> error.
- `Ewr` and `Erd` are never high in the same cycle. `Addr` and `RDir` are stable for the whole cycle in which either enable is high, because DMem writes combinationally.
- Outside RD/WR/RMW states, `Ewr`=`Erd`=0; `Addr`/`RDir` hold their last values.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `Ewr`=0, `Erd`=0, `Addr`=0, `RDir`=0.
- Latency, measured from the accept edge to the first cycle with `resp_valid` high: load 2, word store 2, sub-word store 3, error 1.
- Throughput: one request per latency+1 cycles minimum; `req_ready` returns the cycle after the response handshake.
- `resp_valid` held indefinitely while `resp_ready`=0; response fields stable meanwhile.
- Reset mid-operation: `Ewr` and `Erd` drop asynchronously and any in-flight response is discarded. If reset occurs in WR/RMW_WR, the target word's content is undefined.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is an error (`resp_err`=1, no access).
- Undefined: low address bits below natural alignment are ignored (forced to 0) and the access proceeds normally.

## Structure
- Package `dmem_ctrl_pkg`: size encoding constants, state enum, default `DEPTH_WORDS`.
- Sub-module `dmem_lane_align` (combinational): load extraction/extension and store merge. Inputs: word, offset, size, unsigned flag, store data.

## Test plan
- Store word 0xDEADBEEF at byte addr 0x10, then load word at 0x10 -> `Addr`=4, `resp_rdata`=0xDEADBEEF, `resp_err`=0, latency 2.
- SB 0x80 at addr 0x11 over a word containing 0x00000000 -> `RDir`=0x00008000. Then LB signed -> 0xFFFFFF80; LBU -> 0x00000080.
- SH 0xABCD at addr 0x12 -> word becomes 0xABCD8000. LH at 0x12 -> 0xFFFFABCD.
- LW at 0x13:
  - with `DMEM_MISALIGN_TRAP_EN` -> `resp_err`=1, `Erd` never asserted, latency 1;
  - without it -> data of word index 4.
- LW at addr 0x80 (index 32) -> `resp_err`=1. Also `req_size`=11 -> `resp_err`=1.
- Hold `resp_ready`=0 for 5 cycles -> `resp_valid` and data stable, `req_ready`=0. Assert `rst` during RMW_WR -> all outputs at reset values immediately.
